// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and default frame geometry for sequence_generator
`timescale 1ns/1ps
package seq_gen_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP_WAIT = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP = 1;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shift register, MSB first
// Ports: clk, reset (async active-low), load (capture din), shift (move left one bit),
//        din (parallel word), msb (current serial bit)
`timescale 1ns/1ps
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] shreg;
  always_ff @(posedge clk or negedge reset)
    if (!reset) shreg <= '0;
    else if (load) shreg <= din;
    else if (shift) shreg <= {shreg[WIDTH-2:0], 1'b0};
  assign msb = shreg[WIDTH-1];
endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern source for sequence_detector with one-deep pending buffer
// Ports: clk, reset (async active-low), start_valid/start_ready/pattern (pattern handshake),
//        ser_out/ser_valid (MSB-first frame bits), det_reset (detector clear between frames),
//        done (pulse in first cycle after a frame), busy (frame in flight or word pending)
`timescale 1ns/1ps
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             det_reset,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = $clog2(GAP + 1);
  state_t           state, state_nx;
  logic [WIDTH-1:0] pend;
  logic             pend_full;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic             load, last_bit, gap_end, msb;
  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(ser_valid),
    .din  (pend),
    .msb  (msb)
  );
  // A pending word is pulled in from IDLE or on the last gap cycle, so
  // back-to-back frames have no idle cycle between them.
  always_comb begin
    last_bit = state == SHIFT && cnt == '0;
    gap_end  = state == GAP_WAIT && gcnt == '0;
    load     = pend_full && (state == IDLE || gap_end);
    state_nx = load ? SHIFT : last_bit ? GAP_WAIT : gap_end ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      pend      <= '0;
      pend_full <= 1'b0;
      cnt       <= '0;
      gcnt      <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last_bit;
      // Accept needs an empty slot and transfer needs a full one, so the
      // slot is never freed and refilled on the same edge.
      if (start_valid && start_ready) begin
        pend      <= pattern;
        pend_full <= 1'b1;
      end else if (load) pend_full <= 1'b0;
      if (load) cnt <= CW'(WIDTH - 1);
      else if (state == SHIFT) cnt <= cnt - CW'(1);
      if (last_bit) gcnt <= GW'(GAP - 1);
      else if (state == GAP_WAIT && gcnt != '0) gcnt <= gcnt - GW'(1);
    end
  assign start_ready = !pend_full;
  assign ser_valid   = state == SHIFT;
  assign ser_out     = ser_valid & msb;
  assign det_reset   = state == GAP_WAIT;
  assign busy        = state != IDLE || pend_full;
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed bench for sequence_generator (8/1 and 4/3 builds)
`timescale 1ns/1ps
module tb_sequence_generator;
  import seq_gen_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sv_a = 1'b0, sv_b = 1'b0;
  logic [7:0] pat_a = '0;
  logic [3:0] pat_b = '0;
  logic       ready_a, ser_out_a, ser_valid_a, det_a, done_a, busy_a;
  logic       ready_b, ser_out_b, ser_valid_b, det_b, done_b, busy_b;
  logic [5:0] obs_a, obs_b, exp;
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  // Observation vector: {ser_valid, ser_out, det_reset, done, busy, start_ready}
  assign obs_a = {ser_valid_a, ser_out_a, det_a, done_a, busy_a, ready_a};
  assign obs_b = {ser_valid_b, ser_out_b, det_b, done_b, busy_b, ready_b};
  sequence_generator #(.WIDTH(DEF_WIDTH), .GAP(DEF_GAP)) dut_a (
    .clk(clk), .reset(reset), .start_valid(sv_a), .start_ready(ready_a), .pattern(pat_a),
    .ser_out(ser_out_a), .ser_valid(ser_valid_a), .det_reset(det_a), .done(done_a), .busy(busy_a)
  );
  sequence_generator #(.WIDTH(4), .GAP(3)) dut_b (
    .clk(clk), .reset(reset), .start_valid(sv_b), .start_ready(ready_b), .pattern(pat_b),
    .ser_out(ser_out_b), .ser_valid(ser_valid_b), .det_reset(det_b), .done(done_b), .busy(busy_b)
  );
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a !== 6'b000001) begin failures++; $display("FAIL reset_a got=%b exp=000001", obs_a); end
    checks++;
    if (obs_b !== 6'b000001) begin failures++; $display("FAIL reset_b got=%b exp=000001", obs_b); end
    reset = 1'b1;
    @(negedge clk);
    sv_a = 1'b1; pat_a = 8'h55;
    @(negedge clk);
    sv_a = 1'b0;
    checks++;
    if (obs_a !== 6'b000010) begin failures++; $display("FAIL reset_pending got=%b exp=000010", obs_a); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs_a !== 6'b000001) begin failures++; $display("FAIL reset_async got=%b exp=000001", obs_a); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single_frame;
    logic [7:0] p = 8'b0110_1010;
    sv_a = 1'b1; pat_a = p;
    @(negedge clk);
    sv_a = 1'b0;
    checks++;
    if (obs_a !== 6'b000010) begin failures++; $display("FAIL single_accept got=%b exp=000010", obs_a); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {1'b1, p[7-i], 4'b0011};
      checks++;
      if (obs_a !== exp) begin failures++; $display("FAIL single_bit%0d got=%b exp=%b", i, obs_a, exp); end
    end
    @(negedge clk);
    checks++;
    if (obs_a !== 6'b001111) begin failures++; $display("FAIL single_gap got=%b exp=001111", obs_a); end
    @(negedge clk);
    checks++;
    if (obs_a !== 6'b000001) begin failures++; $display("FAIL single_idle got=%b exp=000001", obs_a); end
  endtask
  task automatic test_back_to_back;
    logic [15:0] s = {8'hCA, 8'h35};
    logic        bit_exp;
    sv_a = 1'b1; pat_a = 8'hCA;
    @(negedge clk);
    sv_a = 1'b0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      bit_exp = (c < 8) ? s[15-c] : (c >= 9 && c <= 16) ? s[16-c] : 1'b0;
      exp = {(c < 8) || (c >= 9 && c <= 16), bit_exp, c == 8 || c == 17, c == 8 || c == 17,
             c < 18, !(c >= 3 && c <= 8)};
      checks++;
      if (obs_a !== exp) begin failures++; $display("FAIL b2b_cycle%0d got=%b exp=%b", c, obs_a, exp); end
      if (c == 2) begin sv_a = 1'b1; pat_a = 8'h35; end
      if (c == 3) sv_a = 1'b0;
    end
  endtask
  task automatic test_backpressure;
    logic [7:0]  q[$];
    logic        rx[$];
    logic [23:0] got = '0;
    logic        last_rdy = 1'b0;
    int          ndet = 0, ndone = 0;
    q = '{8'hFF, 8'h00, 8'hAA};
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (ser_valid_a) rx.push_back(ser_out_a);
      ndet += int'(det_a);
      ndone += int'(done_a);
      if (i == 3 || i == 10) begin
        checks++;
        if (ready_a !== 1'b0) begin failures++; $display("FAIL bp_stall%0d got=%b exp=0", i, ready_a); end
      end
      if (i == 11) begin
        checks++;
        if (ready_a !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", ready_a); end
      end
      if (sv_a && last_rdy) void'(q.pop_front());
      sv_a = q.size() != 0;
      pat_a = (q.size() != 0) ? q[0] : 8'h00;
      last_rdy = ready_a;
    end
    foreach (rx[k]) got = {got[22:0], rx[k]};
    checks++;
    if (rx.size() != 24) begin failures++; $display("FAIL bp_bitcount got=%0d exp=24", rx.size()); end
    checks++;
    if (got !== 24'hFF00AA) begin failures++; $display("FAIL bp_order got=%h exp=ff00aa", got); end
    checks++;
    if (ndet != 3 || ndone != 3) begin failures++; $display("FAIL bp_gaps got=%0d/%0d exp=3/3", ndet, ndone); end
    checks++;
    if (obs_a !== 6'b000001) begin failures++; $display("FAIL bp_idle got=%b exp=000001", obs_a); end
  endtask
  task automatic test_reset_mid_frame;
    logic [7:0] p = 8'h81;
    sv_a = 1'b1; pat_a = 8'hF0;
    @(negedge clk);
    sv_a = 1'b0;
    @(negedge clk);
    sv_a = 1'b1; pat_a = 8'h0F;
    @(negedge clk);
    sv_a = 1'b0;
    checks++;
    if (ready_a !== 1'b0) begin failures++; $display("FAIL mid_pending got=%b exp=0", ready_a); end
    @(negedge clk);
    checks++;
    if (obs_a !== 6'b110010) begin failures++; $display("FAIL mid_bit3 got=%b exp=110010", obs_a); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs_a !== 6'b000001) begin failures++; $display("FAIL mid_async got=%b exp=000001", obs_a); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== 6'b000001) begin failures++; $display("FAIL mid_no_resume%0d got=%b exp=000001", i, obs_a); end
    end
    sv_a = 1'b1; pat_a = p;
    @(negedge clk);
    sv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {1'b1, p[7-i], 4'b0011};
      checks++;
      if (obs_a !== exp) begin failures++; $display("FAIL mid_new_bit%0d got=%b exp=%b", i, obs_a, exp); end
    end
    @(negedge clk);
    checks++;
    if (obs_a !== 6'b001111) begin failures++; $display("FAIL mid_new_gap got=%b exp=001111", obs_a); end
    @(negedge clk);
  endtask
  task automatic test_gap3;
    logic [3:0] p = 4'b1011;
    sv_b = 1'b1; pat_b = p;
    @(negedge clk);
    sv_b = 1'b0;
    checks++;
    if (obs_b !== 6'b000010) begin failures++; $display("FAIL g3_accept got=%b exp=000010", obs_b); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = {1'b1, p[3-i], 4'b0011};
      checks++;
      if (obs_b !== exp) begin failures++; $display("FAIL g3_bit%0d got=%b exp=%b", i, obs_b, exp); end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      exp = {3'b001, j == 0, 2'b11};
      checks++;
      if (obs_b !== exp) begin failures++; $display("FAIL g3_gap%0d got=%b exp=%b", j, obs_b, exp); end
    end
    @(negedge clk);
    checks++;
    if (obs_b !== 6'b000001) begin failures++; $display("FAIL g3_idle got=%b exp=000001", obs_b); end
  endtask
  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_frame;
    test_gap3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
